// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and ALU signal bundle for the shared-ALU arbiter
interface alu_arbiter_if;
   logic       req0;
   logic       req1;
   logic [1:0] op0;
   logic [1:0] op1;
   logic [2:0] a0;
   logic [2:0] b0;
   logic [2:0] a1;
   logic [2:0] b1;
   logic       gnt0;
   logic       gnt1;
   logic       done0;
   logic       done1;
   logic [3:0] result;
   logic       busy;
   logic [1:0] alu_sel;
   logic [2:0] alu_a;
   logic [2:0] alu_b;
   logic [3:0] alu_q;

   modport slave (
      input  req0, req1, op0, op1, a0, b0, a1, b1, alu_q,
      output gnt0, gnt1, done0, done1, result, busy, alu_sel, alu_a, alu_b
   );

   modport master (
      output req0, req1, op0, op1, a0, b0, a1, b1, alu_q,
      input  gnt0, gnt1, done0, done1, result, busy, alu_sel, alu_a, alu_b
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
   parameter int SETTLE_CYCLES = 1
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, RELEASE} state_t;

   state_t     state;
   logic [3:0] count;
   logic       last;
   logic       owner;
   logic [1:0] sel_r;
   logic [2:0] a_r;
   logic [2:0] b_r;
   logic       gnt0_r;
   logic       gnt1_r;
   logic       done0_r;
   logic       done1_r;
   logic       busy_r;
   logic [3:0] result_r;
   logic       win;
   logic       owner_req;

   // On a tie the requester that was not served last takes the ALU.
   always_comb begin
      win = 1'b0;
      if (bus.req0 && bus.req1) begin
         win = ~last;
      end else if (bus.req1) begin
         win = 1'b1;
      end
   end

   assign owner_req = owner ? bus.req1 : bus.req0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= 4'd0;
         last     <= 1'b1;
         owner    <= 1'b0;
         sel_r    <= 2'd0;
         a_r      <= 3'd0;
         b_r      <= 3'd0;
         gnt0_r   <= 1'b0;
         gnt1_r   <= 1'b0;
         done0_r  <= 1'b0;
         done1_r  <= 1'b0;
         busy_r   <= 1'b0;
         result_r <= 4'd0;
      end else begin
         done0_r <= 1'b0;
         done1_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  owner  <= win;
                  gnt0_r <= ~win;
                  gnt1_r <= win;
                  sel_r  <= win ? bus.op1 : bus.op0;
                  a_r    <= win ? bus.a1 : bus.a0;
                  b_r    <= win ? bus.b1 : bus.b0;
                  count  <= 4'(SETTLE_CYCLES);
                  busy_r <= 1'b1;
                  state  <= SETTLE;
               end
            end
            SETTLE: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  result_r <= bus.alu_q;
                  done0_r  <= ~owner;
                  done1_r  <= owner;
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               // Grant is held until the owner lets go of its request.
               if (!owner_req) begin
                  gnt0_r <= 1'b0;
                  gnt1_r <= 1'b0;
                  last   <= owner;
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt0    = gnt0_r;
   assign bus.gnt1    = gnt1_r;
   assign bus.done0   = done0_r;
   assign bus.done1   = done1_r;
   assign bus.busy    = busy_r;
   assign bus.result  = result_r;
   assign bus.alu_sel = sel_r;
   assign bus.alu_a   = a_r;
   assign bus.alu_b   = b_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized scoreboard bench for alu_arbiter
module tb_alu_arbiter;
   logic clk;
   logic rst_n;
   logic sweep_go;
   int   checks;
   int   failures;
   logic m_last;

   typedef struct packed {
      logic       who;
      logic [3:0] res;
   } exp_t;
   exp_t sbq[$];

   function automatic logic [3:0] alu_fn(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
      case (op)
         2'd0:    return {1'b0, a} + {1'b0, b};
         2'd1:    return {1'b0, a} - {1'b0, b};
         2'd2:    return {1'b0, a & b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   alu_arbiter_if u_if();
   assign u_if.alu_q = alu_fn(u_if.alu_sel, u_if.alu_a, u_if.alu_b);

   alu_arbiter #(.SETTLE_CYCLES(1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every done pulse is matched against the oldest expected response.
   always @(negedge clk) begin
      exp_t e;
      if (u_if.done0 || u_if.done1) begin
         chk("done_exclusive", {31'd0, u_if.done0 & u_if.done1}, 32'd0);
         chk("gnt_exclusive", {31'd0, u_if.gnt0 & u_if.gnt1}, 32'd0);
         if (sbq.size() == 0) begin
            chk("unexpected_done", {30'd0, u_if.done1, u_if.done0}, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("done_who", {31'd0, u_if.done1}, {31'd0, e.who});
            chk("result", {28'd0, u_if.result}, {28'd0, e.res});
         end
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int N = (gi == 0) ? 1 : (gi == 1) ? 4 : 15;
      alu_arbiter_if s_if();
      assign s_if.alu_q = alu_fn(s_if.alu_sel, s_if.alu_a, s_if.alu_b);

      alu_arbiter #(.SETTLE_CYCLES(N)) u_sw (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (s_if)
      );

      initial begin
         int edges;
         bit busy_ok;
         s_if.req0 = 1'b0; s_if.req1 = 1'b0; s_if.op0 = 2'd0; s_if.op1 = 2'd0;
         s_if.a0 = 3'd0; s_if.b0 = 3'd0; s_if.a1 = 3'd0; s_if.b1 = 3'd0;
         wait (sweep_go);
         @(negedge clk);
         s_if.req0 = 1'b1; s_if.a0 = 3'd5; s_if.b0 = 3'd6;
         edges = 0;
         busy_ok = 1'b1;
         for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (!s_if.busy) busy_ok = 1'b0;
            if (s_if.done0) break;
         end
         chk($sformatf("latency_n%0d", N), edges, N + 1);
         chk($sformatf("busy_held_n%0d", N), {31'd0, busy_ok}, 32'd1);
         chk($sformatf("sweep_result_n%0d", N), {28'd0, s_if.result}, 32'd11);
         @(negedge clk);
         s_if.req0 = 1'b0;
      end
   end

   function automatic logic [31:0] outs_main();
      return {8'd0, u_if.gnt0, u_if.gnt1, u_if.done0, u_if.done1, u_if.busy,
              u_if.result, u_if.alu_sel, u_if.alu_a, u_if.alu_b};
   endfunction

   task automatic run_txn(input int pattern);
      bit r0, r1, w, first, withdraw;
      bit order[2];
      int nserve, k;
      logic [1:0] op_l;
      logic [2:0] a_l, b_l;
      exp_t e;
      r0 = (pattern != 2);
      r1 = (pattern != 1);
      u_if.op0 = 2'($urandom_range(0, 3)); u_if.a0 = 3'($urandom_range(0, 7)); u_if.b0 = 3'($urandom_range(0, 7));
      u_if.op1 = 2'($urandom_range(0, 3)); u_if.a1 = 3'($urandom_range(0, 7)); u_if.b1 = 3'($urandom_range(0, 7));
      first = (r0 && r1) ? ~m_last : r1;
      order[0] = first;
      order[1] = ~first;
      nserve = (r0 && r1) ? 2 : 1;
      for (int j = 0; j < nserve; j++) begin
         e.who = order[j];
         e.res = order[j] ? alu_fn(u_if.op1, u_if.a1, u_if.b1) : alu_fn(u_if.op0, u_if.a0, u_if.b0);
         sbq.push_back(e);
         m_last = order[j];
      end
      u_if.req0 = r0;
      u_if.req1 = r1;
      for (int j = 0; j < nserve; j++) begin
         w = order[j];
         op_l = w ? u_if.op1 : u_if.op0;
         a_l  = w ? u_if.a1 : u_if.a0;
         b_l  = w ? u_if.b1 : u_if.b0;
         k = 0;
         while (!(w ? u_if.gnt1 : u_if.gnt0) && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("grant_seen", {31'd0, w ? u_if.gnt1 : u_if.gnt0}, 32'd1);
         chk("other_gnt_low", {31'd0, w ? u_if.gnt0 : u_if.gnt1}, 32'd0);
         chk("alu_in_latched", {24'd0, u_if.alu_sel, u_if.alu_a, u_if.alu_b}, {24'd0, op_l, a_l, b_l});
         // Owner's inputs are free to change once granted.
         if (w) begin
            u_if.op1 = 2'($urandom_range(0, 3)); u_if.a1 = 3'($urandom_range(0, 7)); u_if.b1 = 3'($urandom_range(0, 7));
         end else begin
            u_if.op0 = 2'($urandom_range(0, 3)); u_if.a0 = 3'($urandom_range(0, 7)); u_if.b0 = 3'($urandom_range(0, 7));
         end
         withdraw = 1'($urandom_range(0, 1));
         if (withdraw) begin
            if (w) u_if.req1 = 1'b0; else u_if.req0 = 1'b0;
         end
         k = 0;
         while (!(w ? u_if.done1 : u_if.done0) && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("done_seen", {31'd0, w ? u_if.done1 : u_if.done0}, 32'd1);
         chk("alu_in_held", {24'd0, u_if.alu_sel, u_if.alu_a, u_if.alu_b}, {24'd0, op_l, a_l, b_l});
         if (w) u_if.req1 = 1'b0; else u_if.req0 = 1'b0;
         @(negedge clk);
         chk("released_idle", {29'd0, u_if.gnt0, u_if.gnt1, u_if.busy}, 32'd0);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      m_last = 1'b1;
      sweep_go = 1'b0;
      rst_n = 1'b0;
      u_if.req0 = 1'b0; u_if.req1 = 1'b0; u_if.op0 = 2'd0; u_if.op1 = 2'd0;
      u_if.a0 = 3'd0; u_if.b0 = 3'd0; u_if.a1 = 3'd0; u_if.b1 = 3'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", outs_main(), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", outs_main(), 32'd0);

      // Directed single request: 5 + 6 on requester 0.
      u_if.op0 = 2'd0; u_if.a0 = 3'd5; u_if.b0 = 3'd6;
      e_push(1'b0, 4'b1011);
      u_if.req0 = 1'b1;
      @(negedge clk);
      chk("single_gnt0_edge0", {30'd0, u_if.gnt0, u_if.gnt1}, 32'd2);
      @(negedge clk);
      chk("single_done0_edge1", {30'd0, u_if.done0, u_if.done1}, 32'd2);
      chk("single_result", {28'd0, u_if.result}, 32'd11);
      u_if.req0 = 1'b0;
      @(negedge clk);
      chk("single_release", {30'd0, u_if.gnt0, u_if.busy}, 32'd0);
      m_last = 1'b0;

      repeat (2) run_txn(0);
      for (int i = 0; i < 30; i++) begin
         run_txn($urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      sweep_go = 1'b1;
      repeat (40) @(negedge clk);

      // Abort an operation in flight.
      u_if.req0 = 1'b1; u_if.op0 = 2'd1; u_if.a0 = 3'd3; u_if.b0 = 3'd5;
      for (int k = 0; k < 20 && !u_if.gnt0; k++) @(negedge clk);
      chk("midop_gnt0", {31'd0, u_if.gnt0}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("midop_reset_outputs", outs_main(), 32'd0);
      u_if.req0 = 1'b0;
      repeat (2) @(negedge clk);
      chk("midop_no_done", outs_main(), 32'd0);
      rst_n = 1'b1;
      m_last = 1'b1;
      run_txn(2);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic e_push(input logic who, input logic [3:0] res);
      exp_t e;
      e.who = who;
      e.res = res;
      sbq.push_back(e);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
